gslcd_pixel_out: RTL

Pixel output stage directly downstream of the GSLCD timing generator. Buffers an upstream valid/ready pixel stream in a small FIFO and aligns it to the generator's vsync/hsync/active strobes. Drives registered LCD-pin signals and detects underflow and frame misalignment, resynchronising on the next start-of-frame pixel.

---
 rtl/gslcd_pixel_out.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gslcd_pixel_out.sv
// gslcd_pixel_out
// Pixel output stage behind the GSLCD timing generator. A small FIFO buffers
// the upstream {sof, pixel} stream. Pixels are popped on io_active and sent to
// the panel pins alongside the one-cycle-delayed sync strobes. Underflow and
// sof/frame misalignment raise a one-cycle pulse, flush the FIFO and make the
// block wait for the next start-of-frame pixel.
//
// Upstream handshake: a beat transfers on a clock edge where io_in_valid and
// io_in_ready are both high. io_in_ready depends only on registered state
// (FSM state and FIFO fill), never on io_in_valid. A transferred beat may
// still be discarded: non-sof beats while waiting for sof, and any beat in a
// cycle that flushes the FIFO.
module gslcd_pixel_out #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          pclk_clk,
    input  logic                          pclk_reset_n,
    input  logic                          io_enable,
    input  logic                          io_vsync,
    input  logic                          io_hsync,
    input  logic                          io_active,
    input  logic                          io_in_valid,
    output logic                          io_in_ready,
    input  logic [DATA_WIDTH-1:0]         io_in_data,
    input  logic                          io_in_sof,
    output logic                          io_lcd_vsync,
    output logic                          io_lcd_hsync,
    output logic                          io_lcd_de,
    output logic [DATA_WIDTH-1:0]         io_lcd_data,
    output logic                          io_underflow,
    output logic                          io_misalign,
    output logic [$clog2(FIFO_DEPTH):0]   io_level
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     LVL_DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SOF   = 2'd1,
        S_WAIT_VSYNC = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_vsync_d;
    logic                    r_first_px;
    logic [AW:0]             r_wptr;
    logic [AW:0]             r_rptr;
    logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];

    logic [AW:0]             w_level;
    logic                    w_empty;
    logic                    w_full;
    logic [DATA_WIDTH:0]     w_head;
    logic                    w_head_sof;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_head_err;
    logic                    w_vsync_rise;
    logic                    w_accept;
    logic                    w_in_ready;
    logic                    w_pop;
    logic                    w_write;
    logic                    w_flush;
    logic                    w_underflow;
    logic                    w_misalign;
    logic [DATA_WIDTH-1:0]   w_px_data;

    // FIFO status and combinational head
    assign w_level      = r_wptr - r_rptr;
    assign w_empty      = (w_level == '0);
    assign w_full       = (w_level == LVL_DEPTH);
    assign w_head       = r_mem[r_rptr[AW-1:0]];
    assign w_head_sof   = w_head[DATA_WIDTH];
    assign w_head_data  = w_head[DATA_WIDTH-1:0];
    // Head sof must agree with "this is the first pixel of the frame"
    assign w_head_err   = r_first_px ^ w_head_sof;
    assign w_vsync_rise = io_vsync & ~r_vsync_d;
    assign w_accept     = io_in_valid & w_in_ready;

    // FSM state register
    always_ff @(posedge pclk_clk) begin
        if (!pclk_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; disable wins from every state
    always_comb begin
        w_next_state = r_state;
        if (!io_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       w_next_state = S_WAIT_SOF;
                S_WAIT_SOF:   if (w_accept && io_in_sof) w_next_state = S_WAIT_VSYNC;
                S_WAIT_VSYNC: if (w_vsync_rise) w_next_state = S_RUN;
                S_RUN:        if (io_active && (w_empty || w_head_err)) w_next_state = S_WAIT_SOF;
                default:      w_next_state = S_IDLE;
            endcase
        end
    end

    // FSM outputs: ready, pop/write strobes, error detection and flush
    always_comb begin
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE:       w_in_ready = 1'b0;
            S_WAIT_SOF:   w_in_ready = 1'b1;
            S_WAIT_VSYNC: w_in_ready = ~w_full;
            S_RUN:        w_in_ready = ~w_full;
            default:      w_in_ready = 1'b0;
        endcase
        w_underflow = (r_state == S_RUN) && io_enable && io_active && w_empty;
        w_pop       = (r_state == S_RUN) && io_enable && io_active && !w_empty;
        w_misalign  = w_pop && w_head_err;
        // Entering IDLE or (re)entering WAIT_SOF discards everything buffered,
        // including a beat accepted in the same cycle
        w_flush     = (w_next_state == S_IDLE) ||
                      ((w_next_state == S_WAIT_SOF) && (r_state != S_WAIT_SOF));
        w_write     = w_accept && !w_flush &&
                      ((r_state != S_WAIT_SOF) || io_in_sof);
        w_px_data   = w_pop ? w_head_data : '0;
    end

    assign io_in_ready = w_in_ready;
    assign io_level    = w_level;

    // vsync edge detector
    always_ff @(posedge pclk_clk) begin
        if (!pclk_reset_n) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= io_vsync;
        end
    end

    // First-pixel flag: a new frame starts on vsync rise, the next pop consumes it
    always_ff @(posedge pclk_clk) begin
        if (!pclk_reset_n) begin
            r_first_px <= 1'b0;
        end else if (w_vsync_rise && ((r_state == S_WAIT_VSYNC) || (r_state == S_RUN))) begin
            r_first_px <= 1'b1;
        end else if (w_pop) begin
            r_first_px <= 1'b0;
        end
    end

    // FIFO pointers; a flush empties the FIFO at this edge
    always_ff @(posedge pclk_clk) begin
        if (!pclk_reset_n || w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)   r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // FIFO storage, {sof, pixel}; contents are don't-care while empty
    always_ff @(posedge pclk_clk) begin
        if (w_write) begin
            r_mem[r_wptr[AW-1:0]] <= {io_in_sof, io_in_data};
        end
    end

    // Registered panel pins and error pulses; all zero while idle or disabled
    always_ff @(posedge pclk_clk) begin
        if (!pclk_reset_n || !io_enable || (r_state == S_IDLE)) begin
            io_lcd_vsync <= 1'b0;
            io_lcd_hsync <= 1'b0;
            io_lcd_de    <= 1'b0;
            io_lcd_data  <= '0;
            io_underflow <= 1'b0;
            io_misalign  <= 1'b0;
        end else begin
            io_lcd_vsync <= io_vsync;
            io_lcd_hsync <= io_hsync;
            io_lcd_de    <= io_active;
            io_lcd_data  <= w_px_data;
            io_underflow <= w_underflow;
            io_misalign  <= w_misalign;
        end
    end

endmodule
